// File: rtl/plab1_imul_muldiv_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function codes,
// message field widths, FSM state encoding and small decode helpers.
package plab1_imul_muldiv_iter_pkg;

  localparam int unsigned FUNC_NBITS = 3;

  localparam logic [FUNC_NBITS-1:0] FUNC_MUL  = 3'd0;
  localparam logic [FUNC_NBITS-1:0] FUNC_DIV  = 3'd1;
  localparam logic [FUNC_NBITS-1:0] FUNC_DIVU = 3'd2;
  localparam logic [FUNC_NBITS-1:0] FUNC_REM  = 3'd3;
  localparam logic [FUNC_NBITS-1:0] FUNC_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned req_msg_nbits(input int unsigned nbits);
    return FUNC_NBITS + 2 * nbits;
  endfunction

  function automatic logic func_is_signed(input logic [FUNC_NBITS-1:0] f);
    return (f == FUNC_DIV) || (f == FUNC_REM);
  endfunction

endpackage

// File: rtl/plab1_imul_muldiv_iter_dpath.sv
// Datapath for the iterative mul/div unit: operand, accumulator/remainder
// registers, shared adder-subtractor and sign-fix result mux.
// Optional macro PLAB1_IMUL_EARLY_TERM_EN enables early MUL completion.
module plab1_imul_muldiv_iter_dpath
  import plab1_imul_muldiv_iter_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [FUNC_NBITS-1:0] req_func,
  input  logic [NBITS-1:0]      req_a,
  input  logic [NBITS-1:0]      req_b,
  output logic                  early_done,
  output logic [NBITS-1:0]      result
);

  logic [FUNC_NBITS-1:0] func_r;
  logic [NBITS-1:0]      a_r;
  logic [NBITS-1:0]      b_r;
  logic [NBITS-1:0]      acc_r;
  logic [NBITS-1:0]      a_orig_r;
  logic                  neg_r;
  logic                  dz_r;

  logic                  is_mul;
  logic                  req_signed;
  logic                  sa;
  logic                  sb;
  logic [NBITS-1:0]      a_mag;
  logic [NBITS-1:0]      b_mag;
  logic [NBITS:0]        rem_sh;
  logic [NBITS:0]        op1;
  logic [NBITS:0]        op2;
  logic [NBITS+1:0]      sum;
  logic                  ge;

  // One adder serves both MUL (acc + a) and divide (rem_sh - divisor);
  // for divide the carry out of the extra top bit means rem_sh >= divisor.
  always_comb begin
    req_signed = func_is_signed(req_func);
    sa         = req_signed & req_a[NBITS-1];
    sb         = req_signed & req_b[NBITS-1];
    a_mag      = sa ? -req_a : req_a;
    b_mag      = sb ? -req_b : req_b;
    is_mul     = (func_r == FUNC_MUL);
    rem_sh     = {acc_r, a_r[NBITS-1]};
    op1        = is_mul ? {1'b0, acc_r} : rem_sh;
    op2        = is_mul ? {1'b0, a_r} : ~{1'b0, b_r};
    sum        = {1'b0, op1} + {1'b0, op2} + {{(NBITS+1){1'b0}}, ~is_mul};
    ge         = sum[NBITS+1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      func_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc_r    <= '0;
      a_orig_r <= '0;
      neg_r    <= 1'b0;
      dz_r     <= 1'b0;
    end else if (load) begin
      func_r   <= req_func;
      a_r      <= a_mag;
      b_r      <= b_mag;
      acc_r    <= '0;
      a_orig_r <= req_a;
      neg_r    <= (req_func == FUNC_DIV) ? (sa ^ sb) : sa;
      dz_r     <= (req_b == '0);
    end else if (step) begin
      if (is_mul) begin
        if (b_r[0]) acc_r <= sum[NBITS-1:0];
        a_r <= a_r << 1;
        b_r <= b_r >> 1;
      end else begin
        acc_r <= ge ? sum[NBITS-1:0] : rem_sh[NBITS-1:0];
        a_r   <= {a_r[NBITS-2:0], ge};
      end
    end
  end

  always_comb begin
    result = '0;
    case (func_r)
      FUNC_MUL:             result = acc_r;
      FUNC_DIV, FUNC_DIVU:  result = dz_r ? '1 : (neg_r ? -a_r : a_r);
      FUNC_REM, FUNC_REMU:  result = dz_r ? a_orig_r : (neg_r ? -acc_r : acc_r);
      default:              result = '0;
    endcase
  end

`ifdef PLAB1_IMUL_EARLY_TERM_EN
  assign early_done = (func_r == FUNC_MUL) && (b_r[NBITS-1:1] == '0);
`else
  assign early_done = 1'b0;
`endif

endmodule

// File: rtl/plab1_imul_muldiv_iter.sv
// Iterative NBITS-wide MUL/DIV/DIVU/REM/REMU unit behind val/rdy interfaces.
// Control FSM and bit counter; early MUL exit comes from the datapath.
module plab1_imul_muldiv_iter
  import plab1_imul_muldiv_iter_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FUNC_NBITS+2*NBITS-1:0] in_msg,
  input  logic                          in_val,
  output logic                          in_rdy,
  output logic [NBITS-1:0]              out_msg,
  output logic                          out_val,
  input  logic                          out_rdy
);

  localparam int unsigned CW = $clog2(NBITS + 1);

  state_t                state;
  state_t                state_next;
  logic [CW-1:0]         count;
  logic                  load;
  logic                  step;
  logic                  early_done;
  logic [FUNC_NBITS-1:0] req_func;
  logic [NBITS-1:0]      req_a;
  logic [NBITS-1:0]      req_b;

  assign {req_func, req_a, req_b} = in_msg;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= CW'(NBITS);
    else if (step) count <= count - CW'(1);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_val) state_next = CALC;
      CALC:    if ((count == CW'(1)) || early_done) state_next = DONE;
      DONE:    if (out_rdy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_rdy  = (state == IDLE);
    out_val = (state == DONE);
    load    = (state == IDLE) && in_val;
    step    = (state == CALC);
  end

  plab1_imul_muldiv_iter_dpath #(
    .NBITS (NBITS)
  ) dpath (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .req_func   (req_func),
    .req_a      (req_a),
    .req_b      (req_b),
    .early_done (early_done),
    .result     (out_msg)
  );

  // Hands back state and counter so a harness can format its trace line.
  task automatic trace_module(output state_t trace_state, output logic [CW-1:0] trace_count);
    trace_state = state;
    trace_count = count;
  endtask

endmodule

// File: tb/tb_plab1_imul_muldiv_iter.sv
// Table-driven bench for plab1_imul_muldiv_iter at NBITS=32 and NBITS=8,
// with hand-written backpressure, reset-abort and random-delay sequences.
module tb_plab1_imul_muldiv_iter;
  import plab1_imul_muldiv_iter_pkg::*;

`ifdef PLAB1_IMUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    bit          w8;
    logic [2:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          ce;   // CALC cycles for MUL when early termination is on
  } vec_t;

  localparam int NV = 29;

  logic        clk = 1'b0;
  logic        reset;
  logic [66:0] in_msg32;
  logic        in_val32;
  logic        in_rdy32;
  logic [31:0] out_msg32;
  logic        out_val32;
  logic        out_rdy32;
  logic [18:0] in_msg8;
  logic        in_val8;
  logic        in_rdy8;
  logic [7:0]  out_msg8;
  logic        out_val8;
  logic        out_rdy8;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NV];

  plab1_imul_muldiv_iter #(.NBITS(32)) dut32 (
    .clk     (clk),
    .reset   (reset),
    .in_msg  (in_msg32),
    .in_val  (in_val32),
    .in_rdy  (in_rdy32),
    .out_msg (out_msg32),
    .out_val (out_val32),
    .out_rdy (out_rdy32)
  );

  plab1_imul_muldiv_iter #(.NBITS(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .in_msg  (in_msg8),
    .in_val  (in_val8),
    .in_rdy  (in_rdy8),
    .out_msg (out_msg8),
    .out_val (out_val8),
    .out_rdy (out_rdy8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int ua;
    int ub;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    case (f)
      FUNC_MUL:  return 8'(ua * ub);
      FUNC_DIV:  if (b == 8'h00) return 8'hFF; else return 8'(sa / sb);
      FUNC_DIVU: if (b == 8'h00) return 8'hFF; else return 8'(ua / ub);
      FUNC_REM:  if (b == 8'h00) return a;     else return 8'(sa % sb);
      FUNC_REMU: if (b == 8'h00) return a;     else return 8'(ua % ub);
      default:   return 8'h00;
    endcase
  endfunction

  function automatic int calc_cycles8(input logic [2:0] f, input logic [7:0] b);
    int n;
    n = 1;
    if (!(EARLY && f == FUNC_MUL)) return 8;
    for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Latency is counted in cycles after the accepting edge: 1 = first CALC cycle.
  task automatic do_op(input bit w8, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int src_dly, input int snk_dly,
                       output logic [31:0] res, output int lat);
    int guard;
    repeat (src_dly) @(negedge clk);
    if (w8) begin
      in_msg8 = {f, a[7:0], b[7:0]};
      in_val8 = 1'b1;
    end else begin
      in_msg32 = {f, a, b};
      in_val32 = 1'b1;
    end
    guard = 0;
    while (!(w8 ? in_rdy8 : in_rdy32) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_val8  = 1'b0;
    in_val32 = 1'b0;
    lat = 1;
    while (!(w8 ? out_val8 : out_val32) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    repeat (snk_dly) @(negedge clk);
    res = w8 ? {24'h0, out_msg8} : out_msg32;
    if (w8) out_rdy8 = 1'b1;
    else    out_rdy32 = 1'b1;
    @(negedge clk);
    out_rdy8  = 1'b0;
    out_rdy32 = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    int          lat;
    int          elat;
    int          guard;
    bit          seen;

    vecs[0]  = '{1'b0, FUNC_MUL,  32'h00000002, 32'h00000003, 32'h00000006, 2};
    vecs[1]  = '{1'b0, FUNC_MUL,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 2};
    vecs[2]  = '{1'b0, FUNC_MUL,  32'h00000007, 32'h00000001, 32'h00000007, 1};
    vecs[3]  = '{1'b0, FUNC_MUL,  32'h00000009, 32'h00000000, 32'h00000000, 1};
    vecs[4]  = '{1'b0, FUNC_MUL,  32'h12345678, 32'h00000010, 32'h23456780, 5};
    vecs[5]  = '{1'b0, FUNC_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0};
    vecs[6]  = '{1'b0, FUNC_REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0};
    vecs[7]  = '{1'b0, FUNC_DIVU, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 0};
    vecs[8]  = '{1'b0, FUNC_REMU, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 0};
    vecs[9]  = '{1'b0, FUNC_DIV,  32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0};
    vecs[10] = '{1'b0, FUNC_REM,  32'h00000005, 32'h00000000, 32'h00000005, 0};
    vecs[11] = '{1'b0, FUNC_DIVU, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 0};
    vecs[12] = '{1'b0, FUNC_REMU, 32'h80000000, 32'h00000000, 32'h80000000, 0};
    vecs[13] = '{1'b0, FUNC_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0};
    vecs[14] = '{1'b0, FUNC_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0};
    vecs[15] = '{1'b0, FUNC_DIVU, 32'd100,      32'd7,        32'd14,       0};
    vecs[16] = '{1'b0, FUNC_DIV,  32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 0};
    vecs[17] = '{1'b0, FUNC_REM,  32'd20,       32'hFFFFFFFD, 32'h00000002, 0};
    vecs[18] = '{1'b0, FUNC_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 0};
    vecs[19] = '{1'b0, FUNC_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 0};
    vecs[20] = '{1'b0, 3'd5,      32'd12,       32'd3,        32'h00000000, 0};
    vecs[21] = '{1'b0, 3'd7,      32'd12,       32'd3,        32'h00000000, 0};
    vecs[22] = '{1'b1, FUNC_MUL,  32'h7F,       32'h03,       32'h7D,       2};
    vecs[23] = '{1'b1, FUNC_DIV,  32'h80,       32'hFF,       32'h80,       0};
    vecs[24] = '{1'b1, FUNC_REMU, 32'hC8,       32'h0A,       32'h00,       0};
    vecs[25] = '{1'b1, FUNC_DIV,  32'hF9,       32'h02,       32'hFD,       0};
    vecs[26] = '{1'b1, FUNC_REM,  32'hF9,       32'h02,       32'hFF,       0};
    vecs[27] = '{1'b1, FUNC_DIVU, 32'hFF,       32'h81,       32'h01,       0};
    vecs[28] = '{1'b1, FUNC_REMU, 32'hFF,       32'h81,       32'h7E,       0};

    reset     = 1'b1;
    in_msg32  = '0;
    in_val32  = 1'b0;
    out_rdy32 = 1'b0;
    in_msg8   = '0;
    in_val8   = 1'b0;
    out_rdy8  = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_in_rdy32",  in_rdy32,  1);
    chk("reset_out_val32", out_val32, 0);
    chk("reset_out_msg32", out_msg32, 0);
    chk("reset_in_rdy8",   in_rdy8,   1);
    chk("reset_out_val8",  out_val8,  0);
    chk("reset_out_msg8",  out_msg8,  0);

    for (int i = 0; i < NV; i++) begin
      elat = (EARLY && vecs[i].func == FUNC_MUL) ? vecs[i].ce + 1 : (vecs[i].w8 ? 9 : 33);
      do_op(vecs[i].w8, vecs[i].func, vecs[i].a, vecs[i].b, 0, 0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, elat);
    end

    // Backpressure: result held in DONE while a second request waits.
    in_msg32 = {FUNC_MUL, 32'd6, 32'd7};
    in_val32 = 1'b1;
    @(negedge clk);
    in_msg32 = {FUNC_MUL, 32'd3, 32'd3};
    guard = 0;
    while (!out_val32 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_out_val_c%0d", c), out_val32, 1);
      chk($sformatf("bp_out_msg_c%0d", c), out_msg32, 42);
      chk($sformatf("bp_in_rdy_c%0d", c),  in_rdy32,  0);
      @(negedge clk);
    end
    out_rdy32 = 1'b1;
    @(negedge clk);
    out_rdy32 = 1'b0;
    chk("bp_idle_after_handshake", in_rdy32, 1);
    @(negedge clk);
    in_val32 = 1'b0;
    lat = 1;
    while (!out_val32 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_result", out_msg32, 9);
    out_rdy32 = 1'b1;
    @(negedge clk);
    out_rdy32 = 1'b0;

    // Reset in the middle of CALC discards the operation.
    in_msg32 = {FUNC_DIVU, 32'd100, 32'd7};
    in_val32 = 1'b1;
    @(negedge clk);
    in_val32 = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before_reset", in_rdy32, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_rdy",  in_rdy32,  1);
    chk("abort_out_val", out_val32, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_val32) seen = 1'b1;
    end
    chk("abort_no_stale_result", seen, 0);
    do_op(1'b0, FUNC_MUL, 32'd4, 32'd5, 0, 0, res, lat);
    chk("abort_next_result", res, 20);

    // Random source/sink delays on the 8-bit unit.
    for (int n = 0; n < 50; n++) begin
      rf = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      do_op(1'b1, rf, ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 14)), res, lat);
      chk($sformatf("rnd%0d_f%0d_%02h_%02h_result", n, rf, ra[7:0], rb[7:0]),
          res, {24'h0, model8(rf, ra[7:0], rb[7:0])});
      chk($sformatf("rnd%0d_latency", n), lat, calc_cycles8(rf, rb[7:0]) + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
